// File: rtl/data_table_upsert.sv
// Chained hash-table insert engine: walks a bucket chain from its head pointer,
// then overwrites, appends or rejects according to the per-task mode.
module data_table_upsert #(
    parameter int KEY_WIDTH     = 32,
    parameter int VALUE_WIDTH   = 16,
    parameter int BUCKET_WIDTH  = 8,
    parameter int A_WIDTH       = 8,
    parameter int RAM_LATENCY   = 2,
    parameter int MAX_CHAIN_LEN = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [KEY_WIDTH-1:0]                   task_key_i,
    input  logic [VALUE_WIDTH-1:0]                 task_value_i,
    input  logic [BUCKET_WIDTH-1:0]                task_bucket_i,
    input  logic [A_WIDTH-1:0]                     task_head_ptr_i,
    input  logic                                   task_head_ptr_val_i,
    input  logic [1:0]                             task_mode_i,
    input  logic                                   task_valid_i,
    output logic                                   task_ready_o,
    output logic [A_WIDTH-1:0]                     rd_addr_o,
    output logic                                   rd_en_o,
    input  logic [KEY_WIDTH-1:0]                   rd_key_i,
    input  logic [VALUE_WIDTH-1:0]                 rd_value_i,
    input  logic [A_WIDTH-1:0]                     rd_next_ptr_i,
    input  logic                                   rd_next_ptr_val_i,
    output logic [A_WIDTH-1:0]                     wr_addr_o,
    output logic [KEY_WIDTH-1:0]                   wr_key_o,
    output logic [VALUE_WIDTH-1:0]                 wr_value_o,
    output logic [A_WIDTH-1:0]                     wr_next_ptr_o,
    output logic                                   wr_next_ptr_val_o,
    output logic                                   wr_en_o,
    input  logic [A_WIDTH-1:0]                     empty_addr_i,
    input  logic                                   empty_addr_val_i,
    output logic                                   empty_addr_rd_ack_o,
    output logic [BUCKET_WIDTH-1:0]                head_wr_addr_o,
    output logic [A_WIDTH-1:0]                     head_wr_ptr_o,
    output logic                                   head_wr_ptr_val_o,
    output logic                                   head_wr_en_o,
    output logic [2:0]                             result_code_o,
    output logic [KEY_WIDTH-1:0]                   result_key_o,
    output logic [$clog2(MAX_CHAIN_LEN+1)-1:0]     result_chain_len_o,
    output logic                                   result_valid_o,
    input  logic                                   result_ready_i
);

    localparam int CLW = $clog2(MAX_CHAIN_LEN + 1);
    localparam int LW  = $clog2(RAM_LATENCY + 1);
    localparam logic [CLW-1:0] MAX_CNT = CLW'(MAX_CHAIN_LEN);
    localparam logic [LW-1:0]  LAT_END = LW'(RAM_LATENCY);

    localparam logic [1:0] MODE_INSERT_ONLY = 2'd1;
    localparam logic [1:0] MODE_UPDATE_ONLY = 2'd2;

    localparam logic [2:0] RC_INSERTED      = 3'd0;
    localparam logic [2:0] RC_UPDATED       = 3'd1;
    localparam logic [2:0] RC_TABLE_FULL    = 3'd2;
    localparam logic [2:0] RC_KEY_EXISTS    = 3'd3;
    localparam logic [2:0] RC_KEY_NOT_FOUND = 3'd4;
    localparam logic [2:0] RC_CHAIN_LIMIT   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_MATCH_WR,
        S_NOHEAD_WR_HEAD,
        S_NOHEAD_WR_DATA,
        S_TAIL_WR_DATA,
        S_TAIL_UPD_PTR,
        S_RESULT
    } state_t;

    state_t                  state_q, state_d;
    logic [KEY_WIDTH-1:0]    key_q;
    logic [VALUE_WIDTH-1:0]  value_q;
    logic [BUCKET_WIDTH-1:0] bucket_q;
    logic [1:0]              mode_q;
    logic [A_WIDTH-1:0]      rd_addr_q;
    logic [CLW-1:0]          cnt_q;
    logic [LW-1:0]           lat_q;
    logic [A_WIDTH-1:0]      node_addr_q;
    logic [KEY_WIDTH-1:0]    node_key_q;
    logic [VALUE_WIDTH-1:0]  node_value_q;
    logic [A_WIDTH-1:0]      node_next_q;
    logic                    node_next_val_q;
    logic [A_WIDTH-1:0]      new_addr_q;
    logic [2:0]              code_q, code_d;
    logic                    ack_q;

    logic       accept, decide, take_free, capture, follow, lat_done;
    logic [1:0] dmode;

    // Next-state logic; the append/reject decision is shared by the IDLE
    // (no chain) and end-of-walk paths.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        accept    = 1'b0;
        decide    = 1'b0;
        take_free = 1'b0;
        capture   = 1'b0;
        follow    = 1'b0;
        lat_done  = (lat_q == LAT_END);
        dmode     = (state_q == S_IDLE) ? task_mode_i : mode_q;

        case (state_q)
            S_IDLE: begin
                if (task_valid_i) begin
                    accept = 1'b1;
                    if (task_head_ptr_val_i) state_d = S_RD_REQ;
                    else                     decide  = 1'b1;
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (lat_done) begin
                    capture = 1'b1;
                    if (rd_key_i == key_q) begin
                        if (mode_q == MODE_INSERT_ONLY) begin
                            state_d = S_RESULT;
                            code_d  = RC_KEY_EXISTS;
                        end else begin
                            state_d = S_MATCH_WR;
                        end
                    end else if (!rd_next_ptr_val_i) begin
                        decide = 1'b1;
                    end else if (cnt_q == MAX_CNT) begin
                        state_d = S_RESULT;
                        code_d  = RC_CHAIN_LIMIT;
                    end else begin
                        follow  = 1'b1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_MATCH_WR: begin
                state_d = S_RESULT;
                code_d  = RC_UPDATED;
            end
            S_NOHEAD_WR_HEAD: state_d = S_NOHEAD_WR_DATA;
            S_NOHEAD_WR_DATA: begin
                state_d = S_RESULT;
                code_d  = RC_INSERTED;
            end
            S_TAIL_WR_DATA: state_d = S_TAIL_UPD_PTR;
            S_TAIL_UPD_PTR: begin
                state_d = S_RESULT;
                code_d  = RC_INSERTED;
            end
            S_RESULT: if (result_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (decide) begin
            if (dmode == MODE_UPDATE_ONLY) begin
                state_d = S_RESULT;
                code_d  = RC_KEY_NOT_FOUND;
            end else if (!empty_addr_val_i) begin
                state_d = S_RESULT;
                code_d  = RC_TABLE_FULL;
            end else begin
                take_free = 1'b1;
                state_d   = (state_q == S_IDLE) ? S_NOHEAD_WR_HEAD : S_TAIL_WR_DATA;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            code_q          <= '0;
            ack_q           <= 1'b0;
            key_q           <= '0;
            value_q         <= '0;
            bucket_q        <= '0;
            mode_q          <= '0;
            rd_addr_q       <= '0;
            cnt_q           <= '0;
            lat_q           <= '0;
            node_addr_q     <= '0;
            node_key_q      <= '0;
            node_value_q    <= '0;
            node_next_q     <= '0;
            node_next_val_q <= 1'b0;
            new_addr_q      <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ack_q   <= take_free;
            if (accept) begin
                key_q     <= task_key_i;
                value_q   <= task_value_i;
                bucket_q  <= task_bucket_i;
                mode_q    <= task_mode_i;
                rd_addr_q <= task_head_ptr_i;
                cnt_q     <= '0;
            end
            if (state_q == S_RD_REQ) begin
                cnt_q <= cnt_q + CLW'(1);
                lat_q <= LW'(1);
            end else if (state_q == S_RD_WAIT && !lat_done) begin
                lat_q <= lat_q + LW'(1);
            end
            if (capture) begin
                node_addr_q     <= rd_addr_q;
                node_key_q      <= rd_key_i;
                node_value_q    <= rd_value_i;
                node_next_q     <= rd_next_ptr_i;
                node_next_val_q <= rd_next_ptr_val_i;
            end
            if (follow)    rd_addr_q  <= rd_next_ptr_i;
            if (take_free) new_addr_q <= empty_addr_i;
        end
    end

    // Write ports are decoded from state so only one strobe is ever active.
    always_comb begin
        wr_en_o           = 1'b0;
        wr_addr_o         = '0;
        wr_key_o          = '0;
        wr_value_o        = '0;
        wr_next_ptr_o     = '0;
        wr_next_ptr_val_o = 1'b0;
        case (state_q)
            S_MATCH_WR: begin
                wr_en_o           = 1'b1;
                wr_addr_o         = node_addr_q;
                wr_key_o          = node_key_q;
                wr_value_o        = value_q;
                wr_next_ptr_o     = node_next_q;
                wr_next_ptr_val_o = node_next_val_q;
            end
            S_NOHEAD_WR_DATA, S_TAIL_WR_DATA: begin
                wr_en_o    = 1'b1;
                wr_addr_o  = new_addr_q;
                wr_key_o   = key_q;
                wr_value_o = value_q;
            end
            S_TAIL_UPD_PTR: begin
                wr_en_o           = 1'b1;
                wr_addr_o         = node_addr_q;
                wr_key_o          = node_key_q;
                wr_value_o        = node_value_q;
                wr_next_ptr_o     = new_addr_q;
                wr_next_ptr_val_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign head_wr_en_o        = (state_q == S_NOHEAD_WR_HEAD);
    assign head_wr_addr_o      = bucket_q;
    assign head_wr_ptr_o       = new_addr_q;
    assign head_wr_ptr_val_o   = head_wr_en_o;
    assign task_ready_o        = (state_q == S_IDLE);
    assign rd_en_o             = (state_q == S_RD_REQ);
    assign rd_addr_o           = rd_addr_q;
    assign empty_addr_rd_ack_o = ack_q;
    assign result_valid_o      = (state_q == S_RESULT);
    assign result_code_o       = code_q;
    assign result_key_o        = key_q;
    assign result_chain_len_o  = cnt_q;

endmodule
